// File: rtl/sr_pulse_gen_if.sv
// ============================================================================
// sr_pulse_gen_if : request strobes in, latch drives and status out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sr_pulse_gen_if;
  logic set_req;
  logic reset_req;
  logic Sbar;
  logic Rbar;
  logic busy;
  logic done;

  modport master (
    output set_req,
    output reset_req,
    input  Sbar,
    input  Rbar,
    input  busy,
    input  done
  );

  modport slave (
    input  set_req,
    input  reset_req,
    output Sbar,
    output Rbar,
    output busy,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/sr_pulse_gen.sv
// ============================================================================
// sr_pulse_gen : fixed-width active-low Sbar/Rbar pulses for a NAND SR latch
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_pulse_gen #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  sr_pulse_gen_if.slave    bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SET_P = 2'd1;
  localparam logic [1:0] RST_P = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pend_set;
  logic             pend_set_nxt;
  logic             pend_rst;
  logic             pend_rst_nxt;
  logic             sbar_q;
  logic             rbar_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    pend_set_nxt = pend_set;
    pend_rst_nxt = pend_rst;
    state_nxt    = state;
    cnt_nxt      = cnt;

    // Latest strobe replaces any pending op; reset wins a same-cycle tie.
    if (bus.reset_req) begin
      pend_rst_nxt = 1'b1;
      pend_set_nxt = 1'b0;
    end else if (bus.set_req) begin
      pend_set_nxt = 1'b1;
      pend_rst_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (pend_rst_nxt) begin
          state_nxt    = RST_P;
          cnt_nxt      = PULSE_LOAD;
          pend_rst_nxt = 1'b0;
        end else if (pend_set_nxt) begin
          state_nxt    = SET_P;
          cnt_nxt      = PULSE_LOAD;
          pend_set_nxt = 1'b0;
        end
      end
      SET_P, RST_P: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_set <= 1'b0;
      pend_rst <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_set <= pend_set_nxt;
      pend_rst <= pend_rst_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register while still being driven straight from flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sbar_q <= 1'b1;
      rbar_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sbar_q <= (state_nxt != SET_P);
      rbar_q <= (state_nxt != RST_P);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == GAP) && (cnt_nxt == '0);
    end
  end

  assign bus.Sbar = sbar_q;
  assign bus.Rbar = rbar_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_pulse_gen.sv
// ============================================================================
// tb_sr_pulse_gen : directed and random strobes against a cycle-timeline model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sr_pulse_gen;

  localparam int PULSE_W = 4;
  localparam int GAP_W   = 2;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  // Model: at most one operation on the timeline plus one pending slot.
  bit   op_valid;
  bit   op_is_set;
  int   op_start;
  int   op_end;
  bit   pend_s;
  bit   pend_r;
  logic exp_q;
  logic latch_q;

  sr_pulse_gen_if bus ();

  sr_pulse_gen #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W),
    .CNT_W   (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    op_valid = 1'b0;
    pend_s   = 1'b0;
    pend_r   = 1'b0;
  endtask

  // Called #1 after a rising edge: check cycle cyc, apply strobes, advance.
  task automatic step(input logic s, input logic r);
    bit in_op;
    bit pulse;
    in_op = op_valid && (cyc >= op_start) && (cyc <= op_end);
    pulse = in_op && (cyc < op_start + PULSE_W);
    check("Sbar", {31'd0, bus.Sbar}, {31'd0, !(pulse && op_is_set)});
    check("Rbar", {31'd0, bus.Rbar}, {31'd0, !(pulse && !op_is_set)});
    check("busy", {31'd0, bus.busy}, {31'd0, in_op});
    check("done", {31'd0, bus.done}, {31'd0, in_op && (cyc == op_end)});
    check("no_forbidden", {31'd0, (!bus.Sbar && !bus.Rbar)}, 32'd0);

    if (!bus.Sbar) latch_q = 1'b1;
    if (!bus.Rbar) latch_q = 1'b0;
    if (pulse) exp_q = op_is_set;
    check("latch_q", {31'd0, latch_q}, {31'd0, exp_q});

    bus.set_req   = s;
    bus.reset_req = r;
    if (r) begin
      pend_r = 1'b1;
      pend_s = 1'b0;
    end else if (s) begin
      pend_s = 1'b1;
      pend_r = 1'b0;
    end
    if (!in_op && (pend_s || pend_r)) begin
      op_valid  = 1'b1;
      op_is_set = !pend_r;
      op_start  = cyc + 1;
      op_end    = cyc + PULSE_W + GAP_W;
      pend_s    = 1'b0;
      pend_r    = 1'b0;
    end

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    exp_q         = 1'b0;
    latch_q       = 1'b0;
    bus.set_req   = 1'b0;
    bus.reset_req = 1'b0;
    reset_n       = 1'b0;
    model_clear();

    repeat (3) @(posedge clock);
    #1;
    check("rst_Sbar", {31'd0, bus.Sbar}, 32'd1);
    check("rst_Rbar", {31'd0, bus.Rbar}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset_n = 1'b1;

    // Single set pulse, then a simultaneous set+reset (reset wins).
    idle(10);
    step(1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b1);
    idle(10);

    // Set then reset queued behind it.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle(14);

    // Later set overrides the queued reset.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle(14);

    // Duplicate request during a pulse, and a strobe on the final gap cycle.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(4);
    step(1'b1, 1'b0);
    idle(12);

    // Asynchronous reset in the middle of a set pulse.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_Sbar", {31'd0, bus.Sbar}, 32'd1);
    check("async_Rbar", {31'd0, bus.Rbar}, 32'd1);
    check("async_busy", {31'd0, bus.busy}, 32'd0);
    check("async_done", {31'd0, bus.done}, 32'd0);
    if (!bus.Sbar) latch_q = 1'b1;
    exp_q = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
    cyc++;
    @(posedge clock);
    #1;
    cyc++;
    reset_n = 1'b1;
    idle(6);

    // Reset request held high across reset release.
    @(posedge clock);
    #1;
    cyc++;
    reset_n = 1'b0;
    bus.reset_req = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
    reset_n = 1'b1;
    model_clear();
    step(1'b0, 1'b1);
    idle(10);

    // Random strobes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
